l1_l2_req_arbiter: RTL
======================

Name: l1_l2_req_arbiter

Overview:
- Shares one L2 line-request port among N_REQ L1 requesters, such as I-cache and D-cache miss fills and dirty-line writebacks.
- Round-robin arbitration with one transaction in flight at a time.
- Sequences request, response and error return per requester.
- A watchdog converts a lost L2 response into an error response so an L1 miss FSM never hangs.

Parameters:
N_REQ, 4, number of requesters (≥2)
ADDR_WIDTH, 64, byte address width
LINE_BITS, 512, cache line width in bits
TIMEOUT, 1024, max cycles waiting for L2 response; 0 disables watchdog
CNT_WIDTH, 8, width of saturating error counters

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept (one-hot or zero)
req_we  in  N_REQ  1=writeback (write), 0=fill (read)
req_addr  in  N_REQ*ADDR_WIDTH  packed line addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  N_REQ*LINE_BITS  packed writeback lines
resp_valid  out  N_REQ  one-cycle response pulse to the granted requester
resp_rdata  out  LINE_BITS  fill data, shared by all requesters
resp_err  out  1  error flag qualifying resp_valid
l2_req_valid  out  1  request to L2
l2_req_ready  in  1  L2 accepts request
l2_req_we  out  1  request type
l2_req_addr  out  ADDR_WIDTH  line-aligned address
l2_req_wdata  out  LINE_BITS  writeback data
l2_resp_valid  in  1  L2 response valid
l2_resp_rdata  in  LINE_BITS  L2 response data
l2_resp_err  in  1  L2 response error
busy  out  1  state != IDLE
grant_id  out  $clog2(N_REQ)  current or last granted requester
timeout_cnt  out  CNT_WIDTH  saturating count of watchdog expiries
orphan_cnt  out  CNT_WIDTH  saturating count of dropped L2 responses

Behaviour:
- Reset (async, rst_n=0) clears all state regardless of the current transaction; in-flight transaction is abandoned:
  - state=IDLE, rr_ptr=0, grant_id=0, timer=0, counters=0.
  - All outputs 0: req_ready, resp_valid, resp_rdata, resp_err, l2_req_*, busy.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Winner = first i with req_valid[i]=1, scanning circularly from rr_ptr.
  - req_ready[winner]=1 combinationally in the same cycle; this cycle is the handshake.
  - Latch req_we, addr with low $clog2(LINE_BITS/8) bits forced to 0, wdata and grant_id. Go to ISSUE.
  - No valid request: stay in IDLE, req_ready=0.
  - A requester may drop req_valid before it is accepted.
- ISSUE:
  - l2_req_valid=1 with latched fields, held stable until l2_req_ready=1.
  - On handshake go to WAIT with timer=0.
  - No timeout applies in ISSUE; backpressure may be unbounded.
- WAIT:
  - On l2_resp_valid: latch rdata and err, go to RESP.
  - Otherwise timer increments. If TIMEOUT≠0 and timer==TIMEOUT-1: latch rdata=0, err=1, increment timeout_cnt (saturating), go to RESP.
  - If l2_resp_valid arrives in the expiry cycle, the real response wins and is not counted as a timeout.
- RESP:
  - resp_valid[grant_id]=1 for exactly one cycle, with resp_rdata and resp_err; there is no backpressure.
  - rr_ptr <= (grant_id+1) mod N_REQ. Go to IDLE.
  - A new grant is possible in the cycle after RESP.
- Orphan responses: any l2_resp_valid outside WAIT (late response after a timeout, or a response during ISSUE) is dropped and increments orphan_cnt (saturating). resp_valid is not asserted.
- Latency, given immediate l2_req_ready:
  - Accept at cycle T, l2_req_valid at T+1, earliest response accepted at T+2.
  - resp_valid is 1 cycle after the l2_resp_valid cycle.
  - Minimum request-to-request spacing is 4 cycles.
- Writeback responses return resp_valid with rdata=0 and err from L2.
- resp_rdata holds its last value between responses.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,N_REQ-1. No requester waits more than N_REQ-1 transactions.

Test Plan:
- Single read: requester 2, addr 0x1000_0047, L2 answers 3 cycles after accept with data 0xA5…A5. Required:
  - req_ready[2] in the request cycle.
  - l2_req_addr=0x1000_0040.
  - resp_valid[2] one cycle after l2_resp_valid, with rdata=0xA5…A5 and err=0.
- Round-robin: all 4 requesters valid continuously from reset. Grant order is 0,1,2,3,0; each req_ready pulse is one-hot.
- Backpressure: hold l2_req_ready=0 for 20 cycles. l2_req_valid, addr, we and wdata stay constant. No timeout occurs and timeout_cnt=0.
- Watchdog: TIMEOUT=16, no L2 response. Required:
  - resp_valid[grant] with err=1, rdata=0, exactly 16 cycles after the l2 handshake.
  - timeout_cnt=1.
  - A later l2_resp_valid gives orphan_cnt=1 and no resp_valid.
- Error passthrough: writeback from requester 1 with l2_resp_err=1. resp_valid[1] with err=1; timeout_cnt unchanged.
- Reset mid-WAIT: assert rst_n=0 for 1 cycle. All outputs go to 0 asynchronously. After release, a request from requester 3 is granted first (rr_ptr=0 scan) and completes normally.

Source files
------------

// File: rtl/l1_l2_req_arbiter.sv
// Round-robin arbiter that funnels L1 line requests onto a single L2 port,
// one transaction in flight, with a response watchdog and orphan accounting.
module l1_l2_req_arbiter #(
    parameter int N_REQ      = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int LINE_BITS  = 512,
    parameter int TIMEOUT    = 1024,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ-1:0]              req_we,
    input  logic [N_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [N_REQ*LINE_BITS-1:0]    req_wdata,
    output logic [N_REQ-1:0]              resp_valid,
    output logic [LINE_BITS-1:0]          resp_rdata,
    output logic                          resp_err,
    output logic                          l2_req_valid,
    input  logic                          l2_req_ready,
    output logic                          l2_req_we,
    output logic [ADDR_WIDTH-1:0]         l2_req_addr,
    output logic [LINE_BITS-1:0]          l2_req_wdata,
    input  logic                          l2_resp_valid,
    input  logic [LINE_BITS-1:0]          l2_resp_rdata,
    input  logic                          l2_resp_err,
    output logic                          busy,
    output logic [$clog2(N_REQ)-1:0]      grant_id,
    output logic [CNT_WIDTH-1:0]          timeout_cnt,
    output logic [CNT_WIDTH-1:0]          orphan_cnt
);

    localparam int IW   = $clog2(N_REQ);
    localparam int OFFS = $clog2(LINE_BITS / 8);
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // timer starts at 0 in the first WAIT cycle, so expiring at TIMEOUT-2
    // places the error response exactly TIMEOUT cycles after the L2 handshake
    localparam logic [TW-1:0] T_LIMIT = (TIMEOUT >= 2) ? TW'(TIMEOUT - 2) : '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [IW-1:0]          rr_ptr;
    logic [IW-1:0]          grant_q;
    logic [IW-1:0]          win;
    logic [IW-1:0]          idx;
    logic                   found;
    logic                   expire;
    int                     scan;
    logic                   we_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [LINE_BITS-1:0]   wdata_q;
    logic [LINE_BITS-1:0]   rdata_q;
    logic                   err_q;
    logic [TW-1:0]          timer;
    logic [CNT_WIDTH-1:0]   timeout_q;
    logic [CNT_WIDTH-1:0]   orphan_q;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] line_align(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] mask;
        mask = '1;
        mask = mask << OFFS;
        return a & mask;
    endfunction

    function automatic logic [IW-1:0] ptr_next(input logic [IW-1:0] p);
        return (p == IW'(N_REQ - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [N_REQ-1:0] one_hot(input logic [IW-1:0] p);
        logic [N_REQ-1:0] v;
        v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    // Circular scan from rr_ptr; iterating downward lets the nearest requester win.
    always_comb begin
        win   = rr_ptr;
        found = 1'b0;
        idx   = '0;
        scan  = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan = int'(rr_ptr) + k;
            if (scan >= N_REQ) scan = scan - N_REQ;
            idx = IW'(scan);
            if (req_valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        expire    = 1'b0;
        case (state)
            IDLE:  if (found) state_nxt = ISSUE;
            ISSUE: if (l2_req_ready) state_nxt = WAIT;
            WAIT: begin
                if (l2_resp_valid) begin
                    state_nxt = RESP;
                end else if ((TIMEOUT != 0) && (timer >= T_LIMIT)) begin
                    expire    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            grant_q   <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            timer     <= '0;
            timeout_q <= '0;
            orphan_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_q <= win;
                        we_q    <= req_we[win];
                        addr_q  <= line_align(req_addr[win*ADDR_WIDTH +: ADDR_WIDTH]);
                        wdata_q <= req_wdata[win*LINE_BITS +: LINE_BITS];
                    end
                end
                ISSUE: begin
                    if (l2_req_ready) timer <= '0;
                end
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (l2_resp_valid) begin
                        // writebacks carry no fill data back to the L1
                        rdata_q <= we_q ? '0 : l2_resp_rdata;
                        err_q   <= l2_resp_err;
                    end else if (expire) begin
                        rdata_q   <= '0;
                        err_q     <= 1'b1;
                        timeout_q <= sat_inc(timeout_q);
                    end
                end
                RESP: begin
                    rr_ptr <= ptr_next(grant_q);
                end
                default: ;
            endcase
            if (l2_resp_valid && (state != WAIT)) orphan_q <= sat_inc(orphan_q);
        end
    end

    assign req_ready    = ((state == IDLE) && found) ? one_hot(win) : '0;
    assign resp_valid   = (state == RESP) ? one_hot(grant_q) : '0;
    assign resp_rdata   = rdata_q;
    assign resp_err     = (state == RESP) && err_q;
    assign l2_req_valid = (state == ISSUE);
    assign l2_req_we    = we_q;
    assign l2_req_addr  = addr_q;
    assign l2_req_wdata = wdata_q;
    assign busy         = (state != IDLE);
    assign grant_id     = grant_q;
    assign timeout_cnt  = timeout_q;
    assign orphan_cnt   = orphan_q;

endmodule
